// File: rtl/flop_delay_pkg.sv
// Shared definitions for the flop_delay_line delay pipeline.
//   cnt_w(depth)   : width of an occupancy counter able to hold 0..depth
//   DEF_RESET_BIT  : bit value replicated to build the default RESET_VAL
package flop_delay_pkg;

  localparam logic DEF_RESET_BIT = 1'b0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_delay_stage.sv
// One register stage of flop_delay_line: a valid bit plus WIDTH data bits.
// Control priority inside the stage: rst > shift > clr > ld.
//   clk, rst   : clock, synchronous active-high reset (v=0, d=RESET_VAL)
//   shift      : scan shift; d takes scan_d, v holds
//   clr        : clear valid bit, data holds
//   ld         : load v_in; data loads d_in only when v_in=1
//   v, d       : registered valid / data
module flop_delay_stage
  import flop_delay_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clr,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] scan_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (shift) begin
      d <= scan_d;
    end else if (clr) begin
      v <= 1'b0;
    end else if (ld) begin
      v <= v_in;
      // A bubble moving in leaves the old data in place.
      if (v_in) d <= d_in;
    end
  end

endmodule

// File: rtl/flop_delay_line.sv
// Stallable, bubble-collapsing valid/ready delay line of DEPTH stages.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ce                  : clock enable, 0 freezes all state
//   flush               : clears every valid bit, data holds
//   in_valid/in_ready/in_data    : upstream handshake
//   out_valid/out_ready/out_data : downstream handshake (last stage)
//   count               : number of valid stages
//   scan_en/scan_in/scan_out : only when FLOP_DELAY_SCAN_EN is defined
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on the same-side valid, and both valid
// outputs drop to 0 while the line is stalled, flushed or shifting.
// Control priority: rst > scan_en > flush > ce=0 > normal.
module flop_delay_line
  import flop_delay_pkg::*;
#(
  parameter int               WIDTH     = 2,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      flush,
`ifdef FLOP_DELAY_SCAN_EN
  input  logic                      scan_en,
  input  logic                      scan_in,
  output logic                      scan_out,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] scan_d;
  logic [DEPTH-1:0]            rdy;
  logic                        shift;
  logic                        active;

`ifdef FLOP_DELAY_SCAN_EN
  assign shift    = scan_en;
  assign scan_out = d_q[DEPTH-1][WIDTH-1];
`else
  assign shift    = 1'b0;
`endif

  // Normal movement only when nothing of higher priority is asserted.
  assign active = ce & ~flush & ~shift;

  // Stage i can take a new value if it or any stage downstream of it is
  // empty, or the consumer is draining the last stage. Written as an OR
  // over the tail instead of a rippling self-reference.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(v_q[i]);
    end
  end

  assign in_ready  = active & rdy[0];
  assign out_valid = active & v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic             sbit;

    if (i == 0) begin : g_first
      assign v_in = in_valid;
      assign d_in = in_data;
`ifdef FLOP_DELAY_SCAN_EN
      assign sbit = scan_in;
`else
      assign sbit = 1'b0;
`endif
    end else begin : g_rest
      assign v_in = v_q[i-1];
      assign d_in = d_q[i-1];
      assign sbit = d_q[i-1][WIDTH-1];
    end

    // Scan chain runs LSB to MSB within a stage, then into the next stage.
`ifdef FLOP_DELAY_SCAN_EN
    if (WIDTH == 1) begin : g_sc1
      assign scan_d[i] = sbit;
    end else begin : g_scn
      assign scan_d[i] = {d_q[i][WIDTH-2:0], sbit};
    end
`else
    assign scan_d[i] = {WIDTH{sbit}} & '0;
`endif

    flop_delay_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .shift  (shift),
      .clr    (flush),
      .ld     (active & rdy[i]),
      .v_in   (v_in),
      .d_in   (d_in),
      .scan_d (scan_d[i]),
      .v      (v_q[i]),
      .d      (d_q[i])
    );
  end

endmodule

// File: tb/tb_flop_delay_line.sv
// Directed self-checking bench for flop_delay_line (WIDTH=2, DEPTH=3).
module tb_flop_delay_line;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] count;
`ifdef FLOP_DELAY_SCAN_EN
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  flop_delay_line #(.WIDTH(2), .DEPTH(3), .RESET_VAL(2'b00)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
`ifdef FLOP_DELAY_SCAN_EN
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs and let combinational outputs settle.
  task automatic drive(input logic iv, input logic [1:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  logic [1:0] s_val [8];
  logic       s_ov  [8];
  logic [1:0] s_od  [8];
  logic [1:0] s_cnt [8];

  initial begin
    rst = 1'b1; ce = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = 2'b00; out_ready = 1'b0;
`ifdef FLOP_DELAY_SCAN_EN
    scan_en = 1'b0; scan_in = 1'b0;
`endif
    // 1. Reset
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_count",     count, 0);
    check("rst_in_ready",  in_ready, 1);

    // 2. Streaming: push 1,2,3,0 in cycles 0-3, see them in cycles 3-6.
    s_val = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    s_ov  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    s_od  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    s_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 8; k++) begin
      drive(k < 4, s_val[k], 1'b1);
      check($sformatf("stream_ov_%0d", k), out_valid, s_ov[k]);
      if (s_ov[k]) check($sformatf("stream_od_%0d", k), out_data, s_od[k]);
      check($sformatf("stream_cnt_%0d", k), count, s_cnt[k]);
      check($sformatf("stream_ir_%0d", k), in_ready, 1);
      tick();
    end

    // 3. Backpressure: offer 1,2,3,2 with out_ready=0; only 3 fit.
    s_val = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, s_val[k], 1'b0);
      check($sformatf("bp_cnt_%0d", k), count, k);
      check($sformatf("bp_ir_%0d", k), in_ready, k < 3);
      tick();
    end
    // Pop and push together, count stays 3.
    drive(1'b1, 2'd2, 1'b1);
    check("bp_both_ov", out_valid, 1);
    check("bp_both_od", out_data, 1);
    check("bp_both_ir", in_ready, 1);
    tick();
    check("bp_both_cnt", count, 3);
    // Drain: 2, 3, then the item pushed during the pop.
    s_od = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'd0, 1'b1);
      check($sformatf("drain_ov_%0d", k), out_valid, 1);
      check($sformatf("drain_od_%0d", k), out_data, s_od[k]);
      tick();
    end
    check("drain_empty_cnt", count, 0);
    check("drain_empty_ov", out_valid, 0);

    // 4. Single item collapses to the last stage, then ce freezes it.
    drive(1'b1, 2'd3, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    check("bub_c1_ov", out_valid, 0);
    tick();
    check("bub_c2_ov", out_valid, 0);
    tick();
    check("bub_c3_ov",  out_valid, 1);
    check("bub_c3_od",  out_data, 3);
    check("bub_c3_cnt", count, 1);
    check("bub_c3_ir",  in_ready, 1);
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 2'd1, 1'b1);
      check($sformatf("ce0_ir_%0d", k), in_ready, 0);
      check($sformatf("ce0_ov_%0d", k), out_valid, 0);
      check($sformatf("ce0_cnt_%0d", k), count, 1);
      tick();
    end
    ce = 1'b1;
    drive(1'b0, 2'd0, 1'b1);
    check("ce1_ov",  out_valid, 1);
    check("ce1_od",  out_data, 3);
    check("ce1_cnt", count, 1);
    tick();
    check("ce1_after_cnt", count, 0);

    // 5. Flush with two items, then reset together with flush.
    drive(1'b1, 2'd1, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    tick();
    check("fl_pre_cnt", count, 2);
    check("fl_pre_od",  out_data, 1);
    flush = 1'b1;
    drive(1'b1, 2'd3, 1'b1);
    check("fl_ir", in_ready, 0);
    check("fl_ov", out_valid, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'd0, 1'b1);
    check("fl_cnt", count, 0);
    check("fl_ov_after", out_valid, 0);
    check("fl_od_kept", out_data, 1);
    check("fl_ir_after", in_ready, 1);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 2'd3, 1'b1);
    tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    check("rstfl_od",  out_data, 0);
    check("rstfl_cnt", count, 0);

`ifdef FLOP_DELAY_SCAN_EN
    // 6. Scan: one valid item in place, shift 6'b101101 MSB first.
    begin
      logic [5:0] pat;
      pat = 6'b101101;
      drive(1'b1, 2'd2, 1'b0);
      tick();
      drive(1'b0, 2'd0, 1'b0);
      scan_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
        scan_in = (k < 6) ? pat[5-k] : 1'b0;
        #1;
        if (k >= 6) check($sformatf("scan_out_%0d", k - 6), scan_out, pat[11-k]);
        check($sformatf("scan_ov_%0d", k), out_valid, 0);
        tick();
      end
      scan_en = 1'b0;
      #1;
      check("scan_cnt", count, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
